// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Monitors a PWM line: measures period and high time (in clk cycles)
//   between consecutive rising edges, converts them to an integer duty
//   percent with a 7-step restoring divider, and flags a line that has
//   stopped toggling.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   ui_pwm_in      PWM line under measurement
//   uo_period      last valid period (clk cycles)
//   uo_high        last valid high time (clk cycles)
//   uo_meas_valid  one-cycle pulse when uo_period/uo_high update
//   uo_duty        duty percent 0..100, floor(high*100/period)
//   uo_duty_valid  one-cycle pulse when uo_duty updates
//   uo_stuck       no rising edge seen for TIMEOUT cycles
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ui_pwm_in,
  output logic [CNT_W-1:0] uo_period,
  output logic [CNT_W-1:0] uo_high,
  output logic             uo_meas_valid,
  output logic [6:0]       uo_duty,
  output logic             uo_duty_valid,
  output logic             uo_stuck
);

  localparam int unsigned      NW      = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [6:0]       PCT100  = 7'd100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Input path and edge detect
  logic r_sync1, r_sync2, r_prev, r_primed;
  logic w_s, w_rise;

  assign w_s    = SYNC_EN ? r_sync2 : ui_pwm_in;
  // r_primed blocks a false rise on the first cycle after reset
  assign w_rise = r_primed & w_s & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_prev   <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_sync1  <= ui_pwm_in;
      r_sync2  <= r_sync1;
      r_prev   <= w_s;
      r_primed <= 1'b1;
    end
  end

  // Period / high counters, saturating
  logic [CNT_W-1:0] r_per_cnt, r_high_cnt;
  logic             w_per_sat, w_high_sat;

  assign w_per_sat  = (r_per_cnt == CNT_MAX);
  assign w_high_sat = (r_high_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
    end else if (w_rise) begin
      r_per_cnt  <= CNT_W'(1);
      r_high_cnt <= CNT_W'(1);
    end else begin
      if (!w_per_sat)
        r_per_cnt <= r_per_cnt + 1'b1;
      if (w_s && !w_high_sat)
        r_high_cnt <= r_high_cnt + 1'b1;
    end
  end

  // Measurement capture and stuck detection
  logic [CNT_W-1:0] r_period, r_high;
  logic             r_meas_valid, r_armed, r_stuck;
  logic             w_timeout;

  // Counter is about to reach TIMEOUT with no rise this cycle
  assign w_timeout = ~w_rise & ~r_stuck & (r_per_cnt == TO_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period     <= '0;
      r_high       <= '0;
      r_meas_valid <= 1'b0;
      r_armed      <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_rise) begin
        r_stuck <= 1'b0;
        if (!r_armed) begin
          r_armed <= 1'b1;
        end else if (!w_per_sat) begin
          r_period     <= r_per_cnt;
          r_high       <= r_high_cnt;
          r_meas_valid <= 1'b1;
        end
      end else if (w_timeout) begin
        r_stuck <= 1'b1;
        r_armed <= 1'b0;
      end
    end
  end

  // Duty divider
  logic [1:0]       r_state;
  logic [NW-1:0]    r_num;
  logic [CNT_W-1:0] r_den;
  logic [6:0]       r_quo;
  logic [2:0]       r_bit;
  logic             r_force_pend;
  logic [6:0]       r_force_val;
  logic [6:0]       r_duty;
  logic             r_duty_valid;

  logic [NW-1:0]    w_den_sh, w_num_nx;
  logic [6:0]       w_quo_nx, w_force_val;
  logic             w_ge;

  assign w_den_sh    = NW'(r_den) << r_bit;
  assign w_ge        = (r_num >= w_den_sh);
  assign w_num_nx    = w_ge ? (r_num - w_den_sh) : r_num;
  assign w_quo_nx    = r_quo | (w_ge ? (7'd1 << r_bit) : 7'd0);
  assign w_force_val = w_s ? PCT100 : 7'd0;

  // The result is registered on the last DIV step, so it is visible in the
  // DONE cycle; DONE therefore behaves as IDLE and may accept a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_num        <= '0;
      r_den        <= '0;
      r_quo        <= '0;
      r_bit        <= '0;
      r_force_pend <= 1'b0;
      r_force_val  <= '0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      case (r_state)
        ST_DIV: begin
          r_num <= w_num_nx;
          r_quo <= w_quo_nx;
          r_bit <= r_bit - 3'd1;
          if (r_bit == 3'd0) begin
            r_state      <= ST_DONE;
            r_duty_valid <= 1'b1;
            r_force_pend <= 1'b0;
            if (w_timeout)
              r_duty <= w_force_val;
            else if (r_force_pend)
              r_duty <= r_force_val;
            else
              r_duty <= w_quo_nx;
          end else if (w_timeout) begin
            // stuck while busy: forced value replaces the result at the end
            r_force_pend <= 1'b1;
            r_force_val  <= w_force_val;
          end
        end
        default: begin
          if (r_meas_valid) begin
            r_num   <= NW'(r_high) * NW'(PCT100);
            r_den   <= r_period;
            r_quo   <= '0;
            r_bit   <= 3'd6;
            r_state <= ST_DIV;
          end else begin
            r_state <= ST_IDLE;
          end
          if (w_timeout) begin
            r_duty       <= w_force_val;
            r_duty_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign uo_period     = r_period;
  assign uo_high       = r_high;
  assign uo_meas_valid = r_meas_valid;
  assign uo_duty       = r_duty;
  assign uo_duty_valid = r_duty_valid;
  assign uo_stuck      = r_stuck;

endmodule
